// File: rtl/gray_cnt_src.sv
// rtl/gray_cnt_src.sv - up/down binary counter presenting registered Gray codes over a valid/ready handshake
// Optional adjacency checker enabled by defining GRAY_CHK_EN.
module gray_cnt_src #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_bin,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             wrap,
  output logic             err
);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             fire;
  logic             step;

  assign fire = g_valid & g_ready;
  assign step = !ld && fire && en;

  always_comb begin
    bin_nxt  = up_dn ? bin + 1'b1 : bin - 1'b1;
    wrap_nxt = up_dn ? (bin == '1) : (bin == '0);
  end

  // Priority: load, then handshake fire, then presenting the held code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      g_out   <= '0;
      g_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (ld) begin
      bin     <= ld_bin;
      g_out   <= to_gray(ld_bin);
      g_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (fire) begin
      if (en) begin
        bin     <= bin_nxt;
        g_out   <= to_gray(bin_nxt);
        g_valid <= 1'b1;
        wrap    <= wrap_nxt;
      end else begin
        g_valid <= 1'b0;
        wrap    <= 1'b0;
      end
    end else begin
      if (!g_valid && en) begin
        g_valid <= 1'b1;
      end
      wrap <= 1'b0;
    end
  end

`ifdef GRAY_CHK_EN
  logic [WIDTH-1:0] prev_g;
  logic             stepped;
  logic [WIDTH-1:0] diff;
  logic             one_bit;

  assign diff    = g_out ^ prev_g;
  assign one_bit = (diff != '0) && ((diff & (diff - 1'b1)) == '0);

  // prev_g holds the code shown before the most recent step; loads never arm the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_g  <= '0;
      stepped <= 1'b0;
      err     <= 1'b0;
    end else begin
      stepped <= step;
      if (step) begin
        prev_g <= g_out;
      end
      if (stepped && !one_bit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_cnt_src.sv
// tb/tb_gray_cnt_src.sv - randomized self-checking bench for gray_cnt_src against a cycle-level behavioural model
module tb_gray_cnt_src;
  localparam int W = 5;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         ld = 1'b0;
  logic [W-1:0] ld_bin = '0;
  logic [W-1:0] g_out;
  logic         g_valid;
  logic         g_ready = 1'b0;
  logic         wrap;
  logic         err;

  int checks = 0;
  int errors = 0;

  int m_bin;
  bit m_valid;
  bit m_wrap;
  bit m_step;

  gray_cnt_src #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .ld(ld), .ld_bin(ld_bin),
    .g_out(g_out), .g_valid(g_valid), .g_ready(g_ready), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray_of(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_bin = 0; m_valid = 0; m_wrap = 0; m_step = 0;
  endtask

  // One clock edge; the model advances from the inputs held across that edge.
  task automatic tick();
    bit fire;
    @(posedge clk);
    fire = m_valid && g_ready;
    m_step = 0;
    if (ld) begin
      m_bin = int'(ld_bin); m_valid = 0; m_wrap = 0;
    end else if (fire && en) begin
      m_wrap = up_dn ? (m_bin == N - 1) : (m_bin == 0);
      m_bin = up_dn ? (m_bin + 1) % N : (m_bin + N - 1) % N;
      m_valid = 1; m_step = 1;
    end else if (fire) begin
      m_valid = 0; m_wrap = 0;
    end else begin
      if (!m_valid && en) m_valid = 1;
      m_wrap = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1; up_dn = 1; g_ready = 1; ld = 0;
    for (int i = 0; i < 6; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (g_out !== '0) begin errors++; $display("FAIL reset_g_out got=%b exp=00000", g_out); end
    checks++; if (g_valid !== 1'b0) begin errors++; $display("FAIL reset_g_valid got=%b exp=0", g_valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (g_valid !== 1'b1 || g_out !== '0) begin
      errors++; $display("FAIL reset_first_code got=%b/%b exp=1/00000", g_valid, g_out);
    end
  endtask

  task automatic test_up_count();
    logic [W-1:0] k [6];
    int           kidx [6];
    k = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b10000, 5'b00000};
    kidx = '{1, 2, 3, 4, 31, 32};
    do_reset();
    en = 1; up_dn = 1; g_ready = 1; ld = 0;
    tick();
    checks++; if (g_out !== 5'b00000 || g_valid !== 1'b1) begin
      errors++; $display("FAIL up_first got=%b/%b exp=00000/1", g_out, g_valid);
    end
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++; if (g_out !== gray_of(m_bin) || wrap !== m_wrap) begin
        errors++; $display("FAIL up_seq step=%0d got=%b wrap=%b exp=%b wrap=%b", i, g_out, wrap, gray_of(m_bin), m_wrap);
      end
      for (int j = 0; j < 6; j++) begin
        if (kidx[j] == i) begin
          checks++; if (g_out !== k[j] || wrap !== (i == 32)) begin
            errors++; $display("FAIL up_const step=%0d got=%b wrap=%b exp=%b wrap=%b", i, g_out, wrap, k[j], (i == 32));
          end
        end
      end
    end
    tick();
    checks++; if (wrap !== 1'b0 || g_out !== 5'b00001) begin
      errors++; $display("FAIL up_after_wrap got=%b wrap=%b exp=00001 wrap=0", g_out, wrap);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1; up_dn = 1; g_ready = 1; ld = 0;
    tick(); tick(); tick();
    checks++; if (g_out !== 5'b00011) begin errors++; $display("FAIL bp_setup got=%b exp=00011", g_out); end
    g_ready = 0;
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom); up_dn = 1'($urandom);
      tick();
      checks++; if (g_out !== 5'b00011 || g_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%b exp=00011/1", i, g_out, g_valid);
      end
    end
    en = 1; up_dn = 1; g_ready = 1;
    tick();
    checks++; if (g_out !== 5'b00010 || g_out !== gray_of(m_bin)) begin
      errors++; $display("FAIL bp_release got=%b exp=00010", g_out);
    end
  endtask

  task automatic test_load();
    checks++; if (g_valid !== 1'b1) begin errors++; $display("FAIL ld_pre_valid got=%b exp=1", g_valid); end
    ld = 1; ld_bin = 5'b01101; en = 1; g_ready = 1;
    tick();
    ld = 0; g_ready = 0;
    checks++; if (g_out !== 5'b01011 || g_valid !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL ld_value got=%b/%b/%b exp=01011/0/0", g_out, g_valid, wrap);
    end
    tick();
    checks++; if (g_out !== 5'b01011 || g_valid !== 1'b1) begin
      errors++; $display("FAIL ld_present got=%b/%b exp=01011/1", g_out, g_valid);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    en = 1; up_dn = 0; g_ready = 1; ld = 0;
    tick();
    tick();
    checks++; if (g_out !== 5'b10000 || wrap !== 1'b1) begin
      errors++; $display("FAIL dn_wrap got=%b wrap=%b exp=10000 wrap=1", g_out, wrap);
    end
    tick();
    checks++; if (g_out !== 5'b10001 || wrap !== 1'b0) begin
      errors++; $display("FAIL dn_next got=%b wrap=%b exp=10001 wrap=0", g_out, wrap);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] prev;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom % 12) == 0;
      ld_bin = W'($urandom);
      en = ($urandom % 4) != 0;
      up_dn = ($urandom % 3) != 0;
      g_ready = ($urandom % 3) != 0;
      prev = g_out;
      tick();
      checks++; if (g_out !== gray_of(m_bin) || g_valid !== m_valid || wrap !== m_wrap || err !== 1'b0) begin
        errors++; $display("FAIL rnd cyc=%0d got g=%b v=%b w=%b e=%b exp g=%b v=%b w=%b e=0",
                           i, g_out, g_valid, wrap, err, gray_of(m_bin), m_valid, m_wrap);
      end
      if (m_step) begin
        checks++; if ($countones(prev ^ g_out) != 1) begin
          errors++; $display("FAIL rnd_adjacent cyc=%0d got=%b prev=%b bits=%0d exp=1", i, g_out, prev, $countones(prev ^ g_out));
        end
      end
    end
    ld = 0;
  endtask

  task automatic test_checker();
`ifdef GRAY_CHK_EN
    logic [W-1:0] fv;
`endif
    do_reset();
    en = 1; g_ready = 1; ld = 0;
    for (int i = 0; i < 65; i++) begin
      up_dn = 1'($urandom);
      tick();
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clean got=%b exp=0", err); end
`ifdef GRAY_CHK_EN
    fv = g_out ^ 5'b00011;
    force dut.prev_g = fv;
    tick();
    release dut.prev_g;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_detect got=%b exp=1", err); end
    en = 0; g_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk_sticky cyc=%0d got=%b exp=1", i, err); end
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_reset got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
`endif
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_up_count();
    test_backpressure();
    test_load();
    test_down_wrap();
    test_random();
    test_checker();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
